// File: rtl/fpu_instr_sequencer.sv
// fpu_instr_sequencer
// Fetches instructions from a synchronous instruction memory and decodes each one
// into an operand address and a one-hot operation enable for the FPU datapath.
// After each issue it waits for fpu_done before it fetches the next instruction.
// It stops on a halt instruction, at the last memory location, or on abort.

module fpu_instr_sequencer #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 13,
    parameter int OP_W    = 2,
    parameter int PC_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [PC_W-1:0]      imem_addr,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic [ADDR_W-1:0]    dmem_addr,
    output logic [2**OP_W-1:0]   op_en,
    input  logic                 fpu_done,
    output logic                 busy,
    output logic                 halted,
    output logic [PC_W:0]        instr_count
);

    localparam int NUM_OPS = 2**OP_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        WAIT,
        HALT
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [PC_W-1:0]       pc_q;
    logic [PC_W-1:0]       pc_d;
    logic [INSTR_W-1:0]    ir_q;
    logic [INSTR_W-1:0]    ir_d;
    logic [PC_W:0]         count_d;
    logic [PC_W-1:0]       imem_addr_d;
    logic [ADDR_W-1:0]     dmem_addr_d;
    logic [NUM_OPS-1:0]    op_en_d;
    logic                  busy_d;
    logic                  halted_d;
    logic                  pc_last;

    // The instruction register is kept so the last decoded word stays visible
    // for debug. No logic reads it, so its bits are collected here.
    logic                  ir_unused_bits;
    assign ir_unused_bits = ^ir_q;

    assign pc_last = (pc_q == '1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = FETCH;
                FETCH:   state_d = DECODE;
                DECODE:  state_d = imem_data[OP_W] ? HALT : ISSUE;
                ISSUE:   state_d = WAIT;
                WAIT:    if (fpu_done) state_d = pc_last ? HALT : FETCH;
                HALT:    if (start) state_d = FETCH;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and the datapath registers
    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        count_d     = instr_count;
        imem_addr_d = imem_addr;
        dmem_addr_d = dmem_addr;
        op_en_d     = '0;
        if (!abort) begin
            case (state_q)
                IDLE, HALT: begin
                    if (start) begin
                        pc_d        = '0;
                        count_d     = '0;
                        imem_addr_d = '0;
                    end
                end
                DECODE: begin
                    ir_d = imem_data;
                    // The address and the enable are loaded from the memory word
                    // on the DECODE edge. This way op_en and its operand address
                    // are both valid in the ISSUE cycle, and the address holds through WAIT.
                    if (!imem_data[OP_W]) begin
                        dmem_addr_d = imem_data[INSTR_W-1 -: ADDR_W];
                        op_en_d     = NUM_OPS'(1) << imem_data[OP_W-1:0];
                    end
                end
                WAIT: begin
                    if (fpu_done) begin
                        count_d = instr_count + (PC_W+1)'(1);
                        if (!pc_last) begin
                            pc_d        = pc_q + PC_W'(1);
                            imem_addr_d = pc_q + PC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
        busy_d   = (state_d inside {FETCH, DECODE, ISSUE, WAIT});
        halted_d = (state_d == HALT);
    end

    // Registered outputs and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            ir_q        <= '0;
            instr_count <= '0;
            imem_addr   <= '0;
            dmem_addr   <= '0;
            op_en       <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            instr_count <= count_d;
            imem_addr   <= imem_addr_d;
            dmem_addr   <= dmem_addr_d;
            op_en       <= op_en_d;
            busy        <= busy_d;
            halted      <= halted_d;
        end
    end

endmodule

// File: tb/tb_fpu_instr_sequencer.sv
// Self-checking bench for fpu_instr_sequencer. It uses a default-size instance
// and a PC_W=2 instance. Each instance reads a synchronous memory model.

module tb_fpu_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        fpu_done = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [12:0] dmem_addr;
    logic [3:0]  op_en;
    logic        busy;
    logic        halted;
    logic [8:0]  instr_count;

    logic        start_b = 1'b0;
    logic        abort_b = 1'b0;
    logic        fpu_done_b = 1'b0;
    logic [1:0]  imem_addr_b;
    logic [15:0] imem_data_b;
    logic [12:0] dmem_addr_b;
    logic [3:0]  op_en_b;
    logic        busy_b;
    logic        halted_b;
    logic [2:0]  count_b;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_data   <= mem_a[imem_addr];
    always @(posedge clk) imem_data_b <= mem_b[imem_addr_b];

    fpu_instr_sequencer #(.INSTR_W(16), .ADDR_W(13), .OP_W(2), .PC_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .imem_addr(imem_addr), .imem_data(imem_data), .dmem_addr(dmem_addr),
        .op_en(op_en), .fpu_done(fpu_done), .busy(busy), .halted(halted),
        .instr_count(instr_count)
    );

    fpu_instr_sequencer #(.INSTR_W(16), .ADDR_W(13), .OP_W(2), .PC_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .imem_addr(imem_addr_b), .imem_data(imem_data_b), .dmem_addr(dmem_addr_b),
        .op_en(op_en_b), .fpu_done(fpu_done_b), .busy(busy_b), .halted(halted_b),
        .instr_count(count_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [12:0] a, input logic h, input logic [1:0] op);
        return {a, h, op};
    endfunction

    function automatic logic [15:0] rnd_op();
        return {13'($urandom), 1'b0, 2'($urandom)};
    endfunction

    // Starts the program held in mem_a and checks it against a reference walk of
    // the memory. The walk lists the expected issues and finds where execution stops.
    task automatic run_program(input int lat_min, input int lat_max, input int budget);
        logic [3:0]  exp_op[$];
        logic [12:0] exp_addr[$];
        logic [15:0] w;
        int pc, t, n_iss, last_t, last_lat, done_at, lat, exp_t;
        bit stop, timed_out;
        pc = 0;
        stop = 0;
        while (!stop) begin
            w = mem_a[pc];
            if (w[2]) stop = 1;
            else begin
                exp_op.push_back(4'(1) << w[1:0]);
                exp_addr.push_back(w[15:3]);
                if (pc == 255) stop = 1;
                else pc++;
            end
        end
        start = 1;
        tick();
        start = 0;
        t = 1;
        n_cmp++;
        if (busy !== 1'b1 || imem_addr !== 8'd0) begin
            n_err++;
            $display("FAIL start_fetch: busy=%b imem_addr=%0d, want busy=1 imem_addr=0", busy, imem_addr);
        end
        n_iss = 0; done_at = -1; last_t = 0; last_lat = 0; timed_out = 1;
        for (int i = 0; i < budget; i++) begin
            if (op_en !== 4'b0) begin
                if (n_iss < exp_op.size()) begin
                    n_cmp++;
                    if (op_en !== exp_op[n_iss]) begin
                        n_err++;
                        $display("FAIL op_en[%0d]: got %b want %b", n_iss, op_en, exp_op[n_iss]);
                    end
                    n_cmp++;
                    if (dmem_addr !== exp_addr[n_iss]) begin
                        n_err++;
                        $display("FAIL dmem_addr[%0d]: got %h want %h", n_iss, dmem_addr, exp_addr[n_iss]);
                    end
                    exp_t = (n_iss == 0) ? 3 : last_t + last_lat + 3;
                    n_cmp++;
                    if (t != exp_t) begin
                        n_err++;
                        $display("FAIL issue_cycle[%0d]: got %0d want %0d", n_iss, t, exp_t);
                    end
                end else begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_issue: op_en=%b beyond %0d expected issues", op_en, exp_op.size());
                end
                lat = $urandom_range(lat_max, lat_min);
                done_at = t + lat;
                last_t = t;
                last_lat = lat;
                n_iss++;
            end
            if (halted === 1'b1) begin
                timed_out = 0;
                break;
            end
            fpu_done = (t == done_at);
            if (fpu_done && n_iss > 0 && n_iss <= exp_addr.size()) begin
                n_cmp++;
                if (dmem_addr !== exp_addr[n_iss-1]) begin
                    n_err++;
                    $display("FAIL dmem_hold: got %h want %h", dmem_addr, exp_addr[n_iss-1]);
                end
            end
            tick();
            t++;
        end
        fpu_done = 0;
        n_cmp++;
        if (timed_out) begin
            n_err++;
            $display("FAIL halt_timeout: halted=%b after %0d cycles, want 1", halted, budget);
        end
        n_cmp++;
        if (n_iss != exp_op.size()) begin
            n_err++;
            $display("FAIL issue_total: got %0d want %0d", n_iss, exp_op.size());
        end
        n_cmp++;
        if (instr_count !== 9'(exp_op.size())) begin
            n_err++;
            $display("FAIL instr_count: got %0d want %0d", instr_count, exp_op.size());
        end
        n_cmp++;
        if (imem_addr !== 8'(pc) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL halt_pc: imem_addr=%0d busy=%b, want imem_addr=%0d busy=0", imem_addr, busy, pc);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            tick();
        end
        start = 0;
        n_cmp++;
        if ({imem_addr, dmem_addr, op_en, busy, halted, instr_count} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: imem=%0d dmem=%0d op_en=%b busy=%b halted=%b cnt=%0d, want all 0",
                     imem_addr, dmem_addr, op_en, busy, halted, instr_count);
        end
        rst_n = 1;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0 || halted !== 1'b0 || imem_addr !== 8'd0 || op_en !== 4'd0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b halted=%b imem=%0d op_en=%b, want 0/0/0/0",
                     busy, halted, imem_addr, op_en);
        end
    endtask

    task automatic test_program();
        mem_a[0] = mk(13'h0010, 1'b0, 2'd0);
        mem_a[1] = mk(13'h0020, 1'b0, 2'd1);
        mem_a[2] = mk(13'h1FFF, 1'b0, 2'd2);
        mem_a[3] = mk(13'h0001, 1'b0, 2'd3);
        mem_a[4] = mk(13'h0000, 1'b1, 2'd0);
        run_program(2, 2, 100);
        n_cmp++;
        if (halted !== 1'b1) begin
            n_err++;
            $display("FAIL program_halted: got %b want 1", halted);
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(10, 1);
            for (int k = 0; k < n; k++) mem_a[k] = rnd_op();
            mem_a[n] = {13'($urandom), 1'b1, 2'($urandom)};
            run_program(1, 4, 200);
        end
        for (int k = 0; k < 256; k++) mem_a[k] = rnd_op();
        run_program(1, 1, 2000);
    endtask

    task automatic test_ignored_done();
        abort = 1;
        tick();
        abort = 0;
        fpu_done = 1;
        repeat (2) tick();
        fpu_done = 0;
        n_cmp++;
        if (busy !== 1'b0 || halted !== 1'b0 || op_en !== 4'd0) begin
            n_err++;
            $display("FAIL idle_done: busy=%b halted=%b op_en=%b, want 0/0/0", busy, halted, op_en);
        end
        mem_a[0] = mk(13'd5, 1'b0, 2'd0);
        mem_a[1] = mk(13'd6, 1'b0, 2'd1);
        mem_a[2] = mk(13'd0, 1'b1, 2'd0);
        start = 1;
        tick();                         // cycle 1
        start = 0;
        tick();                         // cycle 2
        tick();                         // cycle 3, ISSUE
        n_cmp++;
        if (op_en !== 4'b0001) begin
            n_err++;
            $display("FAIL issue0_op: got %b want 0001", op_en);
        end
        fpu_done = 1;                   // sampled in the ISSUE cycle
        tick();                         // cycle 4
        fpu_done = 0;
        n_cmp++;
        if (op_en !== 4'b0000) begin
            n_err++;
            $display("FAIL op_pulse_width: got %b want 0000", op_en);
        end
        repeat (3) tick();              // cycle 7
        n_cmp++;
        if (imem_addr !== 8'd0 || instr_count !== 9'd0 || busy !== 1'b1 || dmem_addr !== 13'd5) begin
            n_err++;
            $display("FAIL issue_done_ignored: imem=%0d cnt=%0d busy=%b dmem=%0d, want 0/0/1/5",
                     imem_addr, instr_count, busy, dmem_addr);
        end
        fpu_done = 1;
        tick();                         // cycle 8, FETCH
        fpu_done = 0;
        n_cmp++;
        if (imem_addr !== 8'd1 || instr_count !== 9'd1) begin
            n_err++;
            $display("FAIL wait_done: imem=%0d cnt=%0d, want 1/1", imem_addr, instr_count);
        end
        tick();
        tick();                         // cycle 10, ISSUE
        n_cmp++;
        if (op_en !== 4'b0010 || dmem_addr !== 13'd6) begin
            n_err++;
            $display("FAIL issue1: op_en=%b dmem=%0d, want 0010/6", op_en, dmem_addr);
        end
        tick();                         // cycle 11, WAIT
        fpu_done = 1;
        tick();                         // cycle 12, FETCH
        fpu_done = 0;
        tick();                         // cycle 13, DECODE
        tick();                         // cycle 14, HALT
        n_cmp++;
        if (halted !== 1'b1 || instr_count !== 9'd2 || imem_addr !== 8'd2) begin
            n_err++;
            $display("FAIL halt_after_done: halted=%b cnt=%0d imem=%0d, want 1/2/2",
                     halted, instr_count, imem_addr);
        end
    endtask

    task automatic test_pc_end();
        logic [15:0] w;
        int t, n_iss, done_at;
        bit seen_nonzero, wrapped, timed_out;
        for (int k = 0; k < 4; k++) mem_b[k] = rnd_op();
        start_b = 1;
        tick();
        start_b = 0;
        t = 1; n_iss = 0; done_at = -1; seen_nonzero = 0; wrapped = 0; timed_out = 1;
        for (int i = 0; i < 60; i++) begin
            if (imem_addr_b !== 2'd0) seen_nonzero = 1;
            else if (seen_nonzero) wrapped = 1;
            if (op_en_b !== 4'd0) begin
                if (n_iss < 4) begin
                    w = mem_b[n_iss];
                    n_cmp++;
                    if (op_en_b !== (4'(1) << w[1:0])) begin
                        n_err++;
                        $display("FAIL b_op_en[%0d]: got %b want %b", n_iss, op_en_b, 4'(1) << w[1:0]);
                    end
                end
                n_iss++;
                done_at = t + 1;
            end
            if (halted_b === 1'b1) begin
                timed_out = 0;
                break;
            end
            fpu_done_b = (t == done_at);
            tick();
            t++;
        end
        fpu_done_b = 0;
        n_cmp++;
        if (timed_out || wrapped) begin
            n_err++;
            $display("FAIL b_end_halt: halted=%b wrapped=%b, want 1/0", halted_b, wrapped);
        end
        n_cmp++;
        if (n_iss != 4 || count_b !== 3'd4) begin
            n_err++;
            $display("FAIL b_count: issues=%0d instr_count=%0d, want 4/4", n_iss, count_b);
        end
        n_cmp++;
        if (imem_addr_b !== 2'd3) begin
            n_err++;
            $display("FAIL b_pc_held: imem_addr=%0d want 3", imem_addr_b);
        end
    endtask

    task automatic test_abort();
        int stray;
        for (int k = 0; k < 3; k++) mem_a[k] = rnd_op();
        mem_a[3] = mk(13'd0, 1'b1, 2'd0);
        start = 1;
        tick();                         // cycle 1
        start = 0;
        tick();
        tick();                         // cycle 3, ISSUE
        tick();                         // cycle 4, WAIT
        fpu_done = 1;
        tick();                         // cycle 5, FETCH
        fpu_done = 0;
        tick();
        tick();                         // cycle 7, ISSUE
        tick();                         // cycle 8, WAIT
        abort = 1;
        start = 1;
        tick();                         // cycle 9
        abort = 0;
        start = 0;
        n_cmp++;
        if (busy !== 1'b0 || halted !== 1'b0 || op_en !== 4'd0 || instr_count !== 9'd1) begin
            n_err++;
            $display("FAIL abort_idle: busy=%b halted=%b op_en=%b cnt=%0d, want 0/0/0/1",
                     busy, halted, op_en, instr_count);
        end
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            fpu_done = 1'($urandom);
            tick();
            if (op_en !== 4'd0 || busy !== 1'b0) stray++;
        end
        fpu_done = 0;
        n_cmp++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL abort_quiet: %0d active cycles after abort, want 0", stray);
        end
        run_program(1, 3, 200);
    endtask

    task automatic test_reset_in_issue();
        mem_a[0] = mk(13'h0ABC, 1'b0, 2'd0);
        mem_a[1] = mk(13'd0, 1'b1, 2'd0);
        start = 1;
        tick();
        start = 0;
        tick();
        tick();                         // cycle 3, ISSUE
        n_cmp++;
        if (op_en !== 4'b0001) begin
            n_err++;
            $display("FAIL pre_reset_issue: got %b want 0001", op_en);
        end
        #2;
        rst_n = 0;
        #1;
        n_cmp++;
        if (op_en !== 4'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: op_en=%b busy=%b, want 0000/0", op_en, busy);
        end
        tick();
        rst_n = 1;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0 || halted !== 1'b0 || instr_count !== 9'd0 || imem_addr !== 8'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: busy=%b halted=%b cnt=%0d imem=%0d, want 0/0/0/0",
                     busy, halted, instr_count, imem_addr);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem_a[k] = '0;
        for (int k = 0; k < 4; k++) mem_b[k] = '0;
        test_reset();
        test_program();
        test_random();
        test_ignored_done();
        test_pc_end();
        test_abort();
        test_reset_in_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
